// File: rtl/transformation_engine.sv
// Serial multiply-accumulate engine producing FM_WM = FM x W, one element at a time, row-major.
// Optional build macro TRANS_SATURATE_EN clamps the accumulator instead of letting it wrap.
module transformation_engine #(
    parameter int FEATURE_ROWS = 6,
    parameter int FEATURE_COLS = 96,
    parameter int WEIGHT_COLS  = 3,
    parameter int DATA_W       = 5,
    parameter int DOT_PROD_W   = 16,
    parameter int ROW_W        = $clog2(FEATURE_ROWS),
    parameter int COL_W        = $clog2(WEIGHT_COLS),
    parameter int K_W          = $clog2(FEATURE_COLS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  fm_rd_en,
    output logic [ROW_W-1:0]      fm_row,
    output logic [K_W-1:0]        fm_col,
    input  logic [DATA_W-1:0]     fm_data,
    output logic                  w_rd_en,
    output logic [K_W-1:0]        w_row,
    output logic [COL_W-1:0]      w_col,
    input  logic [DATA_W-1:0]     w_data,
    output logic                  fmwm_wr_en,
    output logic [ROW_W-1:0]      fmwm_row,
    output logic [COL_W-1:0]      fmwm_col,
    output logic [DOT_PROD_W-1:0] fmwm_data,
    output logic                  busy,
    output logic                  done_trans
);

    typedef enum logic [2:0] {IDLE, MAC, DRAIN, WRITE, DONE} state_t;

    localparam logic [K_W-1:0]   K_LAST = K_W'(FEATURE_COLS - 1);
    localparam logic [ROW_W-1:0] R_LAST = ROW_W'(FEATURE_ROWS - 1);
    localparam logic [COL_W-1:0] C_LAST = COL_W'(WEIGHT_COLS - 1);

    state_t                state_q, state_d;
    logic [ROW_W-1:0]      r_q, r_d;
    logic [COL_W-1:0]      c_q, c_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [DOT_PROD_W-1:0] acc_q, acc_d;
    logic                  rd_dly_q, rd_dly_d;

    logic                  fm_rd_en_q, fm_rd_en_d;
    logic [ROW_W-1:0]      fm_row_q, fm_row_d;
    logic [K_W-1:0]        fm_col_q, fm_col_d;
    logic [K_W-1:0]        w_row_q, w_row_d;
    logic [COL_W-1:0]      w_col_q, w_col_d;
    logic                  fmwm_wr_en_q, fmwm_wr_en_d;
    logic [ROW_W-1:0]      fmwm_row_q, fmwm_row_d;
    logic [COL_W-1:0]      fmwm_col_q, fmwm_col_d;
    logic [DOT_PROD_W-1:0] fmwm_data_q, fmwm_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [2*DATA_W-1:0]   prod;
    logic [DOT_PROD_W-1:0] acc_sum;

    // Product of the element pair returned by the memories for last cycle's read strobe.
    always_comb begin
        prod = {{DATA_W{1'b0}}, fm_data} * {{DATA_W{1'b0}}, w_data};
`ifdef TRANS_SATURATE_EN
        begin
            logic [DOT_PROD_W:0] sum_wide;
            sum_wide = {1'b0, acc_q} + {1'b0, DOT_PROD_W'(prod)};
            acc_sum  = sum_wide[DOT_PROD_W] ? '1 : sum_wide[DOT_PROD_W-1:0];
        end
`else
        acc_sum = acc_q + DOT_PROD_W'(prod);
`endif
    end

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        c_d      = c_q;
        k_d      = k_q;
        acc_d    = rd_dly_q ? acc_sum : acc_q;
        rd_dly_d = fm_rd_en_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = MAC;
                    r_d     = '0;
                    c_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            MAC: begin
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            DRAIN: state_d = WRITE;
            WRITE: begin
                acc_d = '0;
                k_d   = '0;
                if (c_q != C_LAST) begin
                    c_d     = c_q + COL_W'(1);
                    state_d = MAC;
                end else if (r_q != R_LAST) begin
                    c_d     = '0;
                    r_d     = r_q + ROW_W'(1);
                    state_d = MAC;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state they belong to.
        fm_rd_en_d   = (state_d == MAC);
        fm_row_d     = fm_row_q;
        fm_col_d     = fm_col_q;
        w_row_d      = w_row_q;
        w_col_d      = w_col_q;
        fmwm_wr_en_d = (state_d == WRITE);
        fmwm_row_d   = fmwm_row_q;
        fmwm_col_d   = fmwm_col_q;
        fmwm_data_d  = fmwm_data_q;
        if (state_d == MAC) begin
            fm_row_d = r_d;
            fm_col_d = k_d;
            w_row_d  = k_d;
            w_col_d  = c_d;
        end
        if (state_d == WRITE) begin
            fmwm_row_d  = r_d;
            fmwm_col_d  = c_d;
            fmwm_data_d = acc_d;
        end
        busy_d = (state_d != IDLE) && (state_q != DONE);
        done_d = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            r_q          <= '0;
            c_q          <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            rd_dly_q     <= 1'b0;
            fm_rd_en_q   <= 1'b0;
            fm_row_q     <= '0;
            fm_col_q     <= '0;
            w_row_q      <= '0;
            w_col_q      <= '0;
            fmwm_wr_en_q <= 1'b0;
            fmwm_row_q   <= '0;
            fmwm_col_q   <= '0;
            fmwm_data_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            c_q          <= c_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            rd_dly_q     <= rd_dly_d;
            fm_rd_en_q   <= fm_rd_en_d;
            fm_row_q     <= fm_row_d;
            fm_col_q     <= fm_col_d;
            w_row_q      <= w_row_d;
            w_col_q      <= w_col_d;
            fmwm_wr_en_q <= fmwm_wr_en_d;
            fmwm_row_q   <= fmwm_row_d;
            fmwm_col_q   <= fmwm_col_d;
            fmwm_data_q  <= fmwm_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign fm_rd_en   = fm_rd_en_q;
    assign fm_row     = fm_row_q;
    assign fm_col     = fm_col_q;
    assign w_rd_en    = fm_rd_en_q;
    assign w_row      = w_row_q;
    assign w_col      = w_col_q;
    assign fmwm_wr_en = fmwm_wr_en_q;
    assign fmwm_row   = fmwm_row_q;
    assign fmwm_col   = fmwm_col_q;
    assign fmwm_data  = fmwm_data_q;
    assign busy       = busy_q;
    assign done_trans = done_q;

endmodule

// File: tb/tb_transformation_engine.sv
// Bench for transformation_engine: default-size instance checked every cycle against a matrix-product
// model, plus a small 2x2x4 instance checked against hand-computed write times and values.
module tb_transformation_engine;

    localparam int FR       = 6;
    localparam int FC       = 96;
    localparam int WC       = 3;
    localparam int ELEM     = FC + 2;
    localparam int N_ELEM   = FR * WC;
    localparam int DONE_REL = N_ELEM * ELEM + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic        fm_rd_en, w_rd_en, fmwm_wr_en, busy, done_trans;
    logic [2:0]  fm_row, fmwm_row;
    logic [6:0]  fm_col, w_row;
    logic [1:0]  w_col, fmwm_col;
    logic [4:0]  fm_data = '0;
    logic [4:0]  w_data  = '0;
    logic [15:0] fmwm_data;

    logic        s_start;
    logic        s_fm_rd_en, s_w_rd_en, s_fmwm_wr_en, s_busy, s_done;
    logic [0:0]  s_fm_row, s_w_col, s_fmwm_row, s_fmwm_col;
    logic [1:0]  s_fm_col, s_w_row;
    logic [4:0]  s_fm_data = '0;
    logic [4:0]  s_w_data  = '0;
    logic [15:0] s_fmwm_data;

    transformation_engine dut (
        .clk(clk), .reset(reset), .start(start),
        .fm_rd_en(fm_rd_en), .fm_row(fm_row), .fm_col(fm_col), .fm_data(fm_data),
        .w_rd_en(w_rd_en), .w_row(w_row), .w_col(w_col), .w_data(w_data),
        .fmwm_wr_en(fmwm_wr_en), .fmwm_row(fmwm_row), .fmwm_col(fmwm_col), .fmwm_data(fmwm_data),
        .busy(busy), .done_trans(done_trans)
    );

    transformation_engine #(.FEATURE_ROWS(2), .FEATURE_COLS(4), .WEIGHT_COLS(2)) dut_small (
        .clk(clk), .reset(reset), .start(s_start),
        .fm_rd_en(s_fm_rd_en), .fm_row(s_fm_row), .fm_col(s_fm_col), .fm_data(s_fm_data),
        .w_rd_en(s_w_rd_en), .w_row(s_w_row), .w_col(s_w_col), .w_data(s_w_data),
        .fmwm_wr_en(s_fmwm_wr_en), .fmwm_row(s_fmwm_row), .fmwm_col(s_fmwm_col), .fmwm_data(s_fmwm_data),
        .busy(s_busy), .done_trans(s_done)
    );

    int fm_mem [FR][FC];
    int w_mem  [FC][WC];
    int exp_val [N_ELEM];

    // Memories return data exactly one cycle after a strobe and zero otherwise.
    always @(posedge clk) begin
        if (fm_rd_en) fm_data <= 5'(fm_mem[fm_row][fm_col]);
        else          fm_data <= '0;
        if (w_rd_en)  w_data  <= 5'(w_mem[w_row][w_col]);
        else          w_data  <= '0;
        s_fm_data <= s_fm_rd_en ? 5'd1 : 5'd0;
        s_w_data  <= s_w_rd_en  ? 5'd1 : 5'd0;
    end

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit check_en  = 1'b0;
    int t0        = 0;
    int wr_seen   = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        total_cnt++;
        if (actual == expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_cnt);
    endtask

    // Builds memories for a pattern and computes the expected product matrix directly.
    task automatic applyStimulus(input int pattern);
        for (int r = 0; r < FR; r++)
            for (int k = 0; k < FC; k++)
                fm_mem[r][k] = (pattern == 0) ? r + 1 : (pattern == 1) ? 31 : 0;
        for (int k = 0; k < FC; k++)
            for (int c = 0; c < WC; c++)
                w_mem[k][c] = (pattern == 1) ? 31 : c + 1;
        for (int r = 0; r < FR; r++)
            for (int c = 0; c < WC; c++) begin
                longint s = 0;
                for (int k = 0; k < FC; k++) s += fm_mem[r][k] * w_mem[k][c];
`ifdef TRANS_SATURATE_EN
                exp_val[r*WC+c] = (s > 65535) ? 65535 : int'(s);
`else
                exp_val[r*WC+c] = int'(s % 65536);
`endif
            end
    endtask

    // Per-cycle comparison of the default instance against the timeline implied by the model.
    always @(negedge clk) begin
        if (check_en) begin
            int  rel, p, idx;
            bit  exp_rd, exp_wr;
            rel    = edge_cnt - t0;
            p      = rel % ELEM;
            idx    = rel / ELEM;
            exp_rd = (rel < N_ELEM * ELEM) && (p < FC);
            exp_wr = (rel < N_ELEM * ELEM) && (p == ELEM - 1);
            checkOutput("ctrl{rd,wrd,wr,busy,done}",
                        {fm_rd_en, w_rd_en, fmwm_wr_en, busy, done_trans},
                        {exp_rd, exp_rd, exp_wr, rel < DONE_REL, rel >= DONE_REL});
            if (exp_rd && fm_rd_en)
                checkOutput("rd_addr", {fm_row, fm_col, w_row, w_col},
                            {3'(idx / WC), 7'(p), 7'(p), 2'(idx % WC)});
            if (exp_wr && fmwm_wr_en)
                checkOutput("fmwm_elem", {fmwm_row, fmwm_col, fmwm_data},
                            {3'(idx / WC), 2'(idx % WC), 16'(exp_val[idx])});
            if (fmwm_wr_en) wr_seen++;
        end
    end

    task automatic pulseStart();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitRel(input int n);
        while (edge_cnt - t0 < n) @(negedge clk);
    endtask

    task automatic armRun();
        pulseStart();
        t0       = edge_cnt;
        wr_seen  = 0;
        check_en = 1'b1;
    endtask

    task automatic runFull(input bit extra_starts);
        armRun();
        if (extra_starts) begin
            waitRel(10);
            pulseStart();
            waitRel(500);
            pulseStart();
        end
        waitRel(DONE_REL + 10);
        check_en = 1'b0;
        checkOutput("write_count", wr_seen, N_ELEM);
        checkOutput("done_held", done_trans, 1);
    endtask

    task automatic doReset();
        @(negedge clk) reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rd"}, {fm_rd_en, w_rd_en}, 0);
        checkOutput({tag, "_wr"}, fmwm_wr_en, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done_trans, 0);
        checkOutput({tag, "_addr"}, {fm_row, fm_col, w_row, w_col, fmwm_row, fmwm_col}, 0);
        checkOutput({tag, "_data"}, fmwm_data, 0);
    endtask

    initial begin
        int s0, s_writes, s_done_rel, rel;
        reset   = 1'b0;
        start   = 1'b0;
        s_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        checkOutput("small_reset_done", s_done, 0);
        reset = 1'b1;

        // Small all-ones case: writes of 4 at (0,0),(0,1),(1,0),(1,1), every 6 cycles, done at 25.
        @(negedge clk) s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        s0         = edge_cnt;
        s_writes   = 0;
        s_done_rel = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rel = edge_cnt - s0;
            if (s_fmwm_wr_en) begin
                checkOutput("small_wr_time", rel, 5 + 6 * s_writes);
                checkOutput("small_wr_addr", {s_fmwm_row, s_fmwm_col}, s_writes);
                checkOutput("small_wr_data", s_fmwm_data, 4);
                s_writes++;
            end
            if (s_done && s_done_rel < 0) s_done_rel = rel;
        end
        checkOutput("small_write_count", s_writes, 4);
        checkOutput("small_done_rel", s_done_rel, 25);

        $display("[TB] ramp pattern FM=r+1, W=c+1");
        applyStimulus(0);
        checkOutput("model_pin_5_2", exp_val[5*WC+2], 1728);
        checkOutput("model_pin_0_0", exp_val[0], 96);
        runFull(1'b0);
        doReset();

        $display("[TB] all-31 overflow with extra starts while busy");
        applyStimulus(1);
`ifdef TRANS_SATURATE_EN
        checkOutput("model_pin_sat", exp_val[0], 65535);
`else
        checkOutput("model_pin_wrap", exp_val[0], 26720);
`endif
        runFull(1'b1);
        doReset();

        $display("[TB] reset during third element");
        applyStimulus(0);
        armRun();
        waitRel(2 * ELEM + 20);
        check_en = 1'b0;
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        checkAllZero("midreset");
        reset = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("midreset_done_stays0", done_trans, 0);
        checkOutput("midreset_idle", {busy, fm_rd_en}, 0);
        runFull(1'b0);
        doReset();

        $display("[TB] zero feature matrix, late start ignored");
        applyStimulus(2);
        runFull(1'b0);
        check_en = 1'b1;
        pulseStart();
        waitRel(DONE_REL + 60);
        check_en = 1'b0;
        checkOutput("late_start_no_writes", wr_seen, N_ELEM);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/transformation_engine.md
# transformation_engine

Computes the node-feature × weight product FM_WM = FM × W for the GCN pipeline, one output element at a time, with a serial multiply-accumulate. It reads the feature and weight memories, writes every FM_WM element to the FM_WM memory, and then raises `done_trans`. The combination stage watches `done_trans` and starts its edge aggregation over FM_WM when it goes high. This block sits directly upstream of the combination stage.

## Interface
- FEATURE_ROWS, 6: node count; number of FM rows.
- FEATURE_COLS, 96: feature length K; number of FM columns and W rows.
- WEIGHT_COLS, 3: output feature count; number of W columns.
- DATA_W, 5: unsigned element width of FM and W.
- DOT_PROD_W, 16: accumulator and FM_WM element width.
- ROW_W / COL_W / K_W, $clog2 of FEATURE_ROWS / WEIGHT_COLS / FEATURE_COLS: address widths.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  **synchronous, active-low** reset.
- start  in  1  single-cycle pulse that begins one transformation.
- fm_rd_en  out  1  feature-memory read strobe.
- fm_row  out  ROW_W  feature-memory row address.
- fm_col  out  K_W  feature-memory column address.
- fm_data  in  DATA_W  feature element; valid 1 cycle after `fm_rd_en`.
- w_rd_en  out  1  weight-memory read strobe.
- w_row  out  K_W  weight-memory row address.
- w_col  out  COL_W  weight-memory column address.
- w_data  in  DATA_W  weight element; valid 1 cycle after `w_rd_en`.
- fmwm_wr_en  out  1  FM_WM write strobe.
- fmwm_row  out  ROW_W  FM_WM write row.
- fmwm_col  out  COL_W  FM_WM write column.
- fmwm_data  out  DOT_PROD_W  FM_WM write data.
- busy  out  1  high from the cycle after an accepted start until `done_trans` rises.
- done_trans  out  1  level signal; all FM_WM elements have been written.

## Operation
- State machine states: IDLE, MAC, DRAIN, WRITE, DONE.
- IDLE:
  - `start`=1 moves to MAC.
  - On that transition, row counter r, column counter c, k counter and accumulator are all cleared to 0.
- MAC:
  - Drives `fm_rd_en`=`w_rd_en`=1, `fm_row`=r, `fm_col`=k, `w_row`=k, `w_col`=c.
  - k increments each cycle.
  - On k=FEATURE_COLS-1, moves to DRAIN.
- Accumulate: each cycle after a read strobe, the accumulator takes acc + fm_data×w_data.
  - The product is 2·DATA_W bits, zero-extended to DOT_PROD_W.
- DRAIN: no read strobes; the last product is added.
- WRITE:
  - Drives `fmwm_wr_en`=1, `fmwm_row`=r, `fmwm_col`=c, `fmwm_data`=acc.
  - Clears acc and k.
  - If c<WEIGHT_COLS-1: c++, go to MAC.
  - Else if r<FEATURE_ROWS-1: c=0, r++, go to MAC.
  - Else go to DONE.
- Output order is row-major: r outer, c inner.
- DONE:
  - `done_trans`=1, held until reset.
  - `start` is ignored.
- `start` is also ignored in MAC, DRAIN and WRITE.
- Overflow default: the accumulator wraps modulo 2^DOT_PROD_W.
- Outside the states named above, the strobes are 0 and the address/data outputs hold their last value.

## Timing
- Reset (reset=0 at an edge): state IDLE; all outputs 0 (strobes, addresses, `fmwm_data`, `busy`, `done_trans`); counters and accumulator 0.
- Reset has priority over every other input in the same cycle.
- Reset mid-operation aborts the run. There is no partial `done_trans`. A new `start` is required after release.
- Per output element: FEATURE_COLS + 2 cycles (K in MAC, 1 in DRAIN, 1 in WRITE).
- Start to done: `done_trans` rises FEATURE_ROWS·WEIGHT_COLS·(FEATURE_COLS+2) + 1 cycles after the `start` edge.
  - The first MAC cycle follows the `start` edge.
  - Default parameters: 6·3·98 + 1 = 1765 cycles.
- Memories: read data must be valid exactly 1 cycle after the read strobe. No stalls or backpressure are supported.
- `fmwm_wr_en` is a single cycle per element. Address and data are valid in the same cycle.

## Configuration
- TRANS_SATURATE_EN:
  - When defined, an accumulate that would exceed 2^DOT_PROD_W − 1 clamps to 2^DOT_PROD_W − 1, and the value stays clamped for the rest of that element.
  - When undefined, the accumulator wraps modulo 2^DOT_PROD_W.
- Latency is identical in both builds.

## Test plan
- All-ones, small size (FEATURE_ROWS=2, WEIGHT_COLS=2, FEATURE_COLS=4):
  - `start` pulse → 4 writes of value 4, order (0,0),(0,1),(1,0),(1,1), one every 6 cycles.
  - `done_trans` rises 25 cycles after `start`.
- Default parameters, FM[r][k]=r+1, W[k][c]=c+1:
  - FM_WM[r][c] = 96·(r+1)·(c+1); e.g. FM_WM[5][2] = 1728.
  - `done_trans` at cycle 1765.
- Overflow, all elements 31 at default size:
  - Without the macro, every FM_WM element = 92256 mod 65536 = 26720.
  - With TRANS_SATURATE_EN, every element = 65535.
- Start while busy: `start` pulses at cycles 10 and 500 after the first start → results and done time are unchanged from a single start.
- Reset mid-run:
  - Assert reset=0 during the 3rd element's MAC → all outputs 0 next cycle and `done_trans` stays 0.
  - A new `start` then gives the full correct result.
- Zero matrix: FM=0 → 18 writes of 0, then `done_trans`=1 held; a later `start` has no effect.
